// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope slot.
// Optional feature macro: ADSR_AUTO_RELEASE_EN (adds the sustain-duration register).
package adsr_pkg;

    // Envelope FSM states; encodings are visible to software through read_data.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    // Full-scale accumulator value (1.0 in Q2.14 on the upper half).
    localparam logic [31:0] ENV_MAX     = 32'h4000_0000;
    localparam logic [15:0] SUSTAIN_MAX = 16'h4000;

    // Register map (addr[2:0]).
    localparam logic [2:0] ADDR_ATTACK   = 3'd0;
    localparam logic [2:0] ADDR_DECAY    = 3'd1;
    localparam logic [2:0] ADDR_SUSTAIN  = 3'd2;
    localparam logic [2:0] ADDR_RELEASE  = 3'd3;
    localparam logic [2:0] ADDR_CMD      = 3'd4;
    localparam logic [2:0] ADDR_DURATION = 3'd5;

    // Sustain levels above unity are stored as unity.
    function automatic logic [15:0] clamp_sustain(input logic [15:0] v);
        logic [15:0] res;
        if (v > SUSTAIN_MAX) begin
            res = SUSTAIN_MAX;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/adsr_core.sv
// ADSR envelope FSM and 32-bit amplitude accumulator.
// Commands (start/stop pulses) take priority over the sample tick in the
// same cycle; the tick's arithmetic is then discarded.
// Optional feature macro: ADSR_AUTO_RELEASE_EN (sustain-duration auto release).
module adsr_core
    import adsr_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [31:0] i_a_step,
    input  logic [31:0] i_d_step,
    input  logic [31:0] i_r_step,
    input  logic [15:0] i_sustain,
`ifdef ADSR_AUTO_RELEASE_EN
    input  logic [31:0] i_duration,
`endif
    output logic [31:0] o_acc,
    output adsr_state_t o_state,
    output logic        o_busy
);

    adsr_state_t r_state;
    adsr_state_t w_state_nxt;
    logic [31:0] r_acc;
    logic [31:0] w_acc_nxt;
    logic        r_busy;

    logic [31:0] w_sus;
    logic [32:0] w_att_sum;
    logic [31:0] w_dec_diff;
    logic        w_dec_uf;
    logic [31:0] w_rel_diff;
    logic        w_active;

`ifdef ADSR_AUTO_RELEASE_EN
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
`endif

    assign w_sus      = {i_sustain, 16'h0000};
    assign w_att_sum  = {1'b0, r_acc} + {1'b0, i_a_step};
    assign w_dec_diff = r_acc - i_d_step;
    assign w_dec_uf   = (r_acc < i_d_step);
    assign w_rel_diff = r_acc - i_r_step;
    assign w_active   = (r_state == ST_ATTACK) || (r_state == ST_DECAY) ||
                        (r_state == ST_SUSTAIN);

    // State, accumulator and busy registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_acc   <= 32'h0000_0000;
            r_busy  <= 1'b0;
`ifdef ADSR_AUTO_RELEASE_EN
            r_cnt   <= 32'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
`ifdef ADSR_AUTO_RELEASE_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    // Next-state and accumulator update: commands first, then the tick.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
`ifdef ADSR_AUTO_RELEASE_EN
        w_cnt_nxt   = r_cnt;
`endif
        if (i_start) begin
            // Retrigger keeps the current amplitude to avoid a click.
            w_state_nxt = ST_ATTACK;
        end else if (i_stop && w_active) begin
            w_state_nxt = ST_RELEASE;
        end else if (i_en) begin
            case (r_state)
                ST_IDLE: begin
                    w_acc_nxt = 32'h0000_0000;
                end
                ST_ATTACK: begin
                    if ((i_a_step == 32'd0) || (w_att_sum >= {1'b0, ENV_MAX})) begin
                        w_acc_nxt   = ENV_MAX;
                        w_state_nxt = ST_DECAY;
                    end else begin
                        w_acc_nxt   = w_att_sum[31:0];
                    end
                end
                ST_DECAY: begin
                    if ((i_d_step == 32'd0) || w_dec_uf || (w_dec_diff <= w_sus)) begin
                        w_acc_nxt   = w_sus;
                        w_state_nxt = ST_SUSTAIN;
`ifdef ADSR_AUTO_RELEASE_EN
                        w_cnt_nxt   = 32'd0;
`endif
                    end else begin
                        w_acc_nxt   = w_dec_diff;
                    end
                end
                ST_SUSTAIN: begin
                    // Re-load every tick so sustain rewrites take effect.
                    w_acc_nxt = w_sus;
`ifdef ADSR_AUTO_RELEASE_EN
                    if ((i_duration != 32'd0) && (r_cnt == (i_duration - 32'd1))) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 32'd1;
                    end
`endif
                end
                ST_RELEASE: begin
                    if ((i_r_step == 32'd0) || (r_acc <= i_r_step)) begin
                        w_acc_nxt   = 32'h0000_0000;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_acc_nxt   = w_rel_diff;
                    end
                end
                default: begin
                    w_acc_nxt   = 32'h0000_0000;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_acc_nxt   = r_acc;
        end
    end

    assign o_acc   = r_acc;
    assign o_state = r_state;
    assign o_busy  = r_busy;

endmodule

// File: rtl/mmio_adsr.sv
// MMIO slot wrapping the ADSR envelope core: register file, write decode
// and read-back mux. Envelope and busy come straight from core registers.
// Optional feature macro: ADSR_AUTO_RELEASE_EN (addr 5 sustain duration).
module mmio_adsr
    import adsr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        en,
    output logic [15:0] env,
    output logic        busy
);

    logic [31:0] r_a_step;
    logic [31:0] r_d_step;
    logic [31:0] r_r_step;
    logic [15:0] r_sustain;
`ifdef ADSR_AUTO_RELEASE_EN
    logic [31:0] r_duration;
`endif

    logic        w_wr;
    logic [2:0]  w_addr;
    logic        w_start;
    logic        w_stop;
    logic [31:0] w_acc;
    adsr_state_t w_state;
    logic [2:0]  w_state_bits;
    logic        w_busy;
    logic        w_unused;

    assign w_wr    = cs & write;
    assign w_addr  = addr[2:0];
    assign w_start = w_wr && (w_addr == ADDR_CMD) &&  write_data[0];
    assign w_stop  = w_wr && (w_addr == ADDR_CMD) && !write_data[0];

    // Step/sustain register file; writes become visible next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_step   <= 32'd0;
            r_d_step   <= 32'd0;
            r_r_step   <= 32'd0;
            r_sustain  <= SUSTAIN_MAX;
`ifdef ADSR_AUTO_RELEASE_EN
            r_duration <= 32'd0;
`endif
        end else if (w_wr) begin
            case (w_addr)
                ADDR_ATTACK:   r_a_step   <= write_data;
                ADDR_DECAY:    r_d_step   <= write_data;
                ADDR_SUSTAIN:  r_sustain  <= clamp_sustain(write_data[15:0]);
                ADDR_RELEASE:  r_r_step   <= write_data;
`ifdef ADSR_AUTO_RELEASE_EN
                ADDR_DURATION: r_duration <= write_data;
`endif
                default: begin
                    r_a_step <= r_a_step;
                end
            endcase
        end else begin
            r_a_step <= r_a_step;
        end
    end

    adsr_core u_core (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_en       (en),
        .i_start    (w_start),
        .i_stop     (w_stop),
        .i_a_step   (r_a_step),
        .i_d_step   (r_d_step),
        .i_r_step   (r_r_step),
        .i_sustain  (r_sustain),
`ifdef ADSR_AUTO_RELEASE_EN
        .i_duration (r_duration),
`endif
        .o_acc      (w_acc),
        .o_state    (w_state),
        .o_busy     (w_busy)
    );

    assign w_state_bits = w_state;
    assign env          = w_acc[31:16];
    assign busy         = w_busy;
    assign read_data    = {13'd0, w_state_bits, w_acc[31:16]};

    // Reads are combinational and address-independent; low acc bits are sub-LSB.
    assign w_unused = ^{read, addr[4:3], w_acc[15:0]};

endmodule

// File: tb/tb_mmio_adsr.sv
// Self-checking bench for mmio_adsr: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_mmio_adsr;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        write;
    logic        read;
    logic [4:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        en;
    logic [15:0] env;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mmio_adsr dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .write      (write),
        .read       (read),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .en         (en),
        .env        (env),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: amplitude as a plain signed integer in 2^-30 units.
    localparam longint MAXV = 64'h4000_0000;
    longint m_acc, m_a, m_d, m_r, m_sus, m_dur, m_cnt;
    int     m_st;

    task automatic model_update(input logic rst, input logic c, input logic w,
                                input logic [4:0] a, input logic [31:0] d, input logic e);
        longint v;
        bit     wr_en;
        int     a3;
        v     = longint'({32'd0, d});
        wr_en = c && w;
        a3    = int'(a[2:0]);
        if (rst) begin
            m_acc = 0; m_a = 0; m_d = 0; m_r = 0; m_sus = 64'h4000;
            m_dur = 0; m_cnt = 0; m_st = 0;
        end else begin
            if (wr_en && a3 == 4 && d[0]) begin
                m_st = 1;
            end else if (wr_en && a3 == 4 && !d[0] && m_st >= 1 && m_st <= 3) begin
                m_st = 4;
            end else if (e) begin
                case (m_st)
                    0: m_acc = 0;
                    1: if (m_a == 0 || m_acc + m_a >= MAXV) begin
                           m_acc = MAXV; m_st = 2;
                       end else m_acc = m_acc + m_a;
                    2: if (m_d == 0 || m_acc - m_d <= m_sus * 65536) begin
                           m_acc = m_sus * 65536; m_st = 3; m_cnt = 0;
                       end else m_acc = m_acc - m_d;
                    3: begin
                           m_acc = m_sus * 65536;
`ifdef ADSR_AUTO_RELEASE_EN
                           if (m_dur != 0 && m_cnt == m_dur - 1) m_st = 4;
                           else m_cnt = m_cnt + 1;
`endif
                       end
                    4: if (m_r == 0 || m_acc <= m_r) begin
                           m_acc = 0; m_st = 0;
                       end else m_acc = m_acc - m_r;
                    default: m_st = 0;
                endcase
            end
            if (wr_en) begin
                case (a3)
                    0: m_a = v;
                    1: m_d = v;
                    2: m_sus = ((v & 64'hFFFF) > 64'h4000) ? 64'h4000 : (v & 64'hFFFF);
                    3: m_r = v;
`ifdef ADSR_AUTO_RELEASE_EN
                    5: m_dur = v;
`endif
                    default: ;
                endcase
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; DUT compared with the model #1 after the edge.
    task automatic apply(input logic r, input logic c, input logic w,
                         input logic [4:0] a, input logic [31:0] d, input logic e);
        reset = r; cs = c; write = w; addr = a; write_data = d; en = e; read = c & ~w;
        @(posedge clk);
        model_update(r, c, w, a, d, e);
        #1;
        chk("model_env",   {16'd0, env}, 32'(m_acc >> 16));
        chk("model_state", {29'd0, read_data[18:16]}, 32'(m_st));
        chk("model_busy",  {31'd0, busy}, {31'd0, (m_st != 0)});
    endtask

    // Compare against constants derived by hand.
    task automatic expect_env(input string nm, input logic [15:0] e_env, input logic [2:0] e_st);
        chk({nm, "_rdata"}, read_data, {13'd0, e_st, e_env});
        chk({nm, "_env"},   {16'd0, env}, {16'd0, e_env});
        chk({nm, "_busy"},  {31'd0, busy}, {31'd0, (e_st != 3'd0)});
    endtask

    task automatic wreg(input logic [4:0] a, input logic [31:0] d);
        apply(1'b0, 1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic tick();
        apply(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    typedef struct {
        logic        cs;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        en;
        logic [15:0] exp_env;
        logic [2:0]  exp_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic w, input logic [4:0] a,
                                input logic [31:0] d, input logic e,
                                input logic [15:0] ee, input logic [2:0] es);
        vec_t v;
        v.cs = c; v.wr = w; v.addr = a; v.wd = d; v.en = e;
        v.exp_env = ee; v.exp_st = es;
        return v;
    endfunction

    initial begin
        reset = 1'b1; cs = 1'b0; write = 1'b0; read = 1'b0;
        addr = 5'd0; write_data = 32'd0; en = 1'b0;

        // Directed table: programme, attack, decay, sustain, release to idle.
        vecs.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 16'h0000, 3'd0));
        vecs.push_back(mk(1'b1, 1'b1, 5'd0, 32'h1000_0000, 1'b0, 16'h0000, 3'd0));
        vecs.push_back(mk(1'b1, 1'b1, 5'd1, 32'h0800_0000, 1'b0, 16'h0000, 3'd0));
        vecs.push_back(mk(1'b1, 1'b1, 5'd2, 32'h0000_2000, 1'b0, 16'h0000, 3'd0));
        vecs.push_back(mk(1'b1, 1'b1, 5'd4, 32'h1,         1'b0, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h1000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h2000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h3000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h4000, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h3800, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h3000, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h2800, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h2000, 3'd3));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h2000, 3'd3));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h2000, 3'd3));
        vecs.push_back(mk(1'b1, 1'b1, 5'd3, 32'h0C00_0000, 1'b0, 16'h2000, 3'd3));
        vecs.push_back(mk(1'b1, 1'b1, 5'd4, 32'h0,         1'b0, 16'h2000, 3'd4));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h1400, 3'd4));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h0800, 3'd4));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h0000, 3'd0));
        vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 16'h0000, 3'd0));

        // Reset state.
        apply(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        expect_env("reset", 16'h0000, 3'd0);

        foreach (vecs[i]) begin
            apply(1'b0, vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].en);
            expect_env($sformatf("vec%0d", i), vecs[i].exp_env, vecs[i].exp_st);
        end

        // Retrigger during release keeps the amplitude.
        wreg(5'd4, 32'h1);
        for (int k = 0; k < 8; k++) tick();
        expect_env("to_sustain", 16'h2000, 3'd3);
        wreg(5'd4, 32'h0);
        tick();
        expect_env("rel_1400", 16'h1400, 3'd4);
        wreg(5'd4, 32'h1);
        expect_env("retrig", 16'h1400, 3'd1);
        tick();
        expect_env("retrig_tick", 16'h2400, 3'd1);
        tick();
        expect_env("att_3400", 16'h3400, 3'd1);

        // Start in the same cycle as a saturating tick: tick discarded.
        apply(1'b0, 1'b1, 1'b1, 5'd4, 32'h1, 1'b1);
        expect_env("cmd_prio", 16'h3400, 3'd1);
        tick();
        expect_env("sat", 16'h4000, 3'd2);

        // Sustain clamp, then sustain rewrite tracking.
        wreg(5'd2, 32'h0000_7000);
        tick();
        expect_env("clamp", 16'h4000, 3'd3);
        wreg(5'd2, 32'h0000_1000);
        tick();
        expect_env("sus_track", 16'h1000, 3'd3);

        // Reset mid-envelope.
        apply(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        expect_env("mid_reset", 16'h0000, 3'd0);

        // Zero steps are instant; stop in IDLE does nothing.
        wreg(5'd4, 32'h1);
        tick();
        expect_env("inst_att", 16'h4000, 3'd2);
        tick();
        expect_env("inst_dec", 16'h4000, 3'd3);
        wreg(5'd4, 32'h0);
        tick();
        expect_env("inst_rel", 16'h0000, 3'd0);
        apply(1'b0, 1'b1, 1'b1, 5'd4, 32'h0, 1'b1);
        expect_env("stop_idle", 16'h0000, 3'd0);

`ifdef ADSR_AUTO_RELEASE_EN
        // Auto release three ticks after entering SUSTAIN.
        wreg(5'd2, 32'h0000_3000);
        wreg(5'd5, 32'd3);
        wreg(5'd4, 32'h1);
        tick();
        tick();
        expect_env("ar_enter", 16'h3000, 3'd3);
        tick();
        expect_env("ar_t1", 16'h3000, 3'd3);
        tick();
        expect_env("ar_t2", 16'h3000, 3'd3);
        tick();
        expect_env("ar_t3", 16'h3000, 3'd4);
`endif

        // Randomized traffic against the model.
        apply(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int n = 0; n < 4000; n++) begin
            int          r;
            logic [4:0]  a;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'($urandom_range(0, 5));
            if (r < 1) begin
                apply(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            end else if (r < 16) begin
                if (a[2:0] == 3'd4) d = 32'($urandom_range(0, 1));
                else if (a[2:0] == 3'd2) d = 32'($urandom_range(0, 32'h0000_5000));
                else if (a[2:0] == 3'd5) d = 32'($urandom_range(0, 6));
                else if ($urandom_range(0, 5) == 0) d = 32'd0;
                else d = 32'($urandom_range(1, 32'h0800_0000));
                apply(1'b0, 1'($urandom_range(0, 9) != 0), 1'b1, a, d, 1'($urandom_range(0, 1)));
            end else begin
                apply(1'b0, 1'b0, 1'b0, a, 32'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
